blob_tracker: RTL and testbench

Per-frame bright-object tracker on the processed VGA pixel stream, sitting after the image-processing stage and before the VGA DAC. It thresholds pixel luminance and accumulates coordinate sums and a pixel count over the frame. At frame end it computes the centroid with an iterative divider, publishes it with a one-cycle valid pulse, and overlays a crosshair at the last centroid on the outgoing video. It is the parametrised successor to the fixed 512x512 barycentre block, adding configurable widths, a runtime threshold, a minimum-count detect, and an optional bounding box.

---
 rtl/blob_pkg.sv | 23 ++
 rtl/blob_div.sv | 61 ++++++
 rtl/blob_tracker.sv | 273 +++++++++++++++++++++++++++
 tb/tb_blob_tracker.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/blob_pkg.sv
// blob_pkg: shared types and helpers for the blob tracker.
// Holds the tracker state enum, the overlay colours and the luminance function.
package blob_pkg;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    DIV_X = 2'd1,
    DIV_Y = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [23:0] XHAIR_RGB = 24'hFF0000;
  localparam logic [23:0] BOX_RGB   = 24'h00FF00;

  // lum = (r + 2g + b) / 4; a 10-bit sum never overflows (max 1020).
  function automatic logic [7:0] lum8(input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
    logic [9:0] s;
    s = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    return s[9:2];
  endfunction

endpackage

// File: rtl/blob_div.sv
// blob_div: restoring shift-subtract divider, one quotient bit per cycle.
// start loads the operands and the index of the top quotient bit (msb);
// the run lasts msb+1 cycles. done is high in the final cycle, and in that
// cycle quotient already includes the last bit. A new start restarts at once.
module blob_div #(
  parameter int DW = 29,
  parameter int NW = 19,
  parameter int QW = 10,
  parameter int KW = 4
) (
  input  logic          vga_clk,
  input  logic          reset,
  input  logic          start,
  input  logic [KW-1:0] msb,
  input  logic [DW-1:0] dividend,
  input  logic [NW-1:0] divisor,
  output logic [QW-1:0] quotient,
  output logic          done
);

  logic          run_q;
  logic [KW-1:0] k_q;
  logic [DW-1:0] rem_q;
  logic [DW-1:0] trial;
  logic [NW-1:0] n_q;
  logic [QW-1:0] q_q;
  logic [QW-1:0] bit_m;
  logic          fits;

  // Trial subtract of (n << k) against the running remainder.
  always_comb begin
    trial    = DW'(n_q) << k_q;
    fits     = rem_q >= trial;
    bit_m    = QW'(1) << k_q;
    quotient = fits ? (q_q | bit_m) : q_q;
    done     = run_q && (k_q == '0);
  end

  // Iteration state: load on start, otherwise step k down to zero.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      run_q <= 1'b0;
      k_q   <= '0;
      rem_q <= '0;
      n_q   <= '0;
      q_q   <= '0;
    end else if (start) begin
      run_q <= 1'b1;
      k_q   <= msb;
      rem_q <= dividend;
      n_q   <= divisor;
      q_q   <= '0;
    end else if (run_q) begin
      if (fits) rem_q <= rem_q - trial;
      q_q <= quotient;
      if (k_q == '0) run_q <= 1'b0;
      else           k_q   <= k_q - KW'(1);
    end
  end

endmodule

// File: rtl/blob_tracker.sv
// blob_tracker: per-frame bright-object centroid tracker with crosshair overlay.
// Thresholds luminance, accumulates count and coordinate sums per frame, divides
// at the vsync falling edge and overlays a crosshair at the last centroid.
// Optional macro BBOX_EN adds a per-frame bounding box and its green outline.
module blob_tracker
  import blob_pkg::*;
#(
  parameter int XW        = 10,
  parameter int YW        = 9,
  parameter int MIN_COUNT = 16
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic             img,
  input  logic             vsync,
  input  logic [XW-1:0]    x,
  input  logic [YW-1:0]    y,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  input  logic [7:0]       lum_thr,
  output logic [7:0]       r_out,
  output logic [7:0]       g_out,
  output logic [7:0]       b_out,
  output logic [XW-1:0]    cx,
  output logic [YW-1:0]    cy,
  output logic [XW+YW-1:0] cnt,
  output logic             detect,
  output logic             centroid_valid,
  output logic             busy,
  output logic [XW-1:0]    bbox_x0,
  output logic [XW-1:0]    bbox_x1,
  output logic [YW-1:0]    bbox_y0,
  output logic [YW-1:0]    bbox_y1
);

  localparam int NW  = XW + YW;
  localparam int SXW = 2 * XW + YW;
  localparam int SYW = XW + 2 * YW;
  localparam int QM  = (XW > YW) ? XW : YW;
  localparam int DW  = NW + QM;
  localparam int KW  = $clog2(QM + 1);
  localparam logic [NW-1:0] MINC = NW'(MIN_COUNT);

  state_e         state_q, state_d;
  logic           vsync_q, frame_end, sel;
  logic [NW-1:0]  acc_n_q, acc_n_d, n_q, cnt_q;
  logic [SXW-1:0] acc_x_q, acc_x_d;
  logic [SYW-1:0] acc_y_q, acc_y_d, sy_q;
  logic [XW-1:0]  qx_q, cx_q;
  logic [YW-1:0]  qy_q, cy_q;
  logic           det_q, box_hit, det_new;
  logic [23:0]    rgb_q, rgb_d;
  logic           div_start, div_done;
  logic [KW-1:0]  div_msb;
  logic [DW-1:0]  div_dividend;
  logic [NW-1:0]  div_divisor;
  logic [QM-1:0]  div_quot;

  assign frame_end = vsync_q & ~vsync;
  assign sel       = img && (lum8(r_in, g_in, b_in) >= lum_thr);
  assign det_new   = n_q >= MINC;

  // Frame accumulators; the frame-end cycle hands them over and restarts at zero.
  always_comb begin
    acc_n_d = acc_n_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    if (frame_end) begin
      acc_n_d = '0;
      acc_x_d = '0;
      acc_y_d = '0;
    end else if (sel) begin
      acc_n_d = acc_n_q + NW'(1);
      acc_x_d = acc_x_q + SXW'(x);
      acc_y_d = acc_y_q + SYW'(y);
    end
  end

  // Next state and divider control; a frame end preempts any running division.
  always_comb begin
    state_d      = state_q;
    div_start    = 1'b0;
    div_msb      = '0;
    div_dividend = '0;
    div_divisor  = n_q;
    if (frame_end) begin
      div_divisor  = acc_n_q;
      div_dividend = DW'(acc_x_q);
      div_msb      = KW'(XW - 1);
      if (acc_n_q >= MINC) begin
        div_start = 1'b1;
        state_d   = DIV_X;
      end else begin
        state_d = DONE;
      end
    end else begin
      case (state_q)
        DIV_X: if (div_done) begin
          div_start    = 1'b1;
          div_dividend = DW'(sy_q);
          div_msb      = KW'(YW - 1);
          state_d      = DIV_Y;
        end
        DIV_Y: if (div_done) state_d = DONE;
        DONE:  state_d = ACCUM;
        default: ;
      endcase
    end
  end

  // State, accumulators and the frame-end snapshot of count and Y sum.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      vsync_q <= 1'b0;
      acc_n_q <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      n_q     <= '0;
      sy_q    <= '0;
    end else begin
      state_q <= state_d;
      vsync_q <= vsync;
      acc_n_q <= acc_n_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      if (frame_end) begin
        n_q  <= acc_n_q;
        sy_q <= acc_y_q;
      end
    end
  end

  // Quotient capture per axis, then publish in DONE (centroid only on detect).
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      qx_q  <= '0;
      qy_q  <= '0;
      cx_q  <= '0;
      cy_q  <= '0;
      cnt_q <= '0;
      det_q <= 1'b0;
    end else begin
      if (state_q == DIV_X && div_done && !frame_end) qx_q <= div_quot[XW-1:0];
      if (state_q == DIV_Y && div_done && !frame_end) qy_q <= div_quot[YW-1:0];
      if (state_q == DONE) begin
        cnt_q <= n_q;
        det_q <= det_new;
        if (det_new) begin
          cx_q <= qx_q;
          cy_q <= qy_q;
        end
      end
    end
  end

  blob_div #(
    .DW(DW),
    .NW(NW),
    .QW(QM),
    .KW(KW)
  ) u_div (
    .vga_clk (vga_clk),
    .reset   (reset),
    .start   (div_start),
    .msb     (div_msb),
    .dividend(div_dividend),
    .divisor (div_divisor),
    .quotient(div_quot),
    .done    (div_done)
  );

`ifdef BBOX_EN
  logic [XW-1:0] fx0_q, fx0_d, fx1_q, fx1_d, lx0_q, lx1_q, ox0_q, ox1_q;
  logic [YW-1:0] fy0_q, fy0_d, fy1_q, fy1_d, ly0_q, ly1_q, oy0_q, oy1_q;

  // Per-frame min/max of selected pixels; min starts at all-ones.
  always_comb begin
    fx0_d = fx0_q;
    fx1_d = fx1_q;
    fy0_d = fy0_q;
    fy1_d = fy1_q;
    if (frame_end) begin
      fx0_d = '1;
      fx1_d = '0;
      fy0_d = '1;
      fy1_d = '0;
    end else if (sel) begin
      if (x < fx0_q) fx0_d = x;
      if (x > fx1_q) fx1_d = x;
      if (y < fy0_q) fy0_d = y;
      if (y > fy1_q) fy1_d = y;
    end
  end

  // Box tracking, snapshot at frame end, publish with the centroid.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fx0_q <= '1;
      fx1_q <= '0;
      fy0_q <= '1;
      fy1_q <= '0;
      lx0_q <= '0;
      lx1_q <= '0;
      ly0_q <= '0;
      ly1_q <= '0;
      ox0_q <= '0;
      ox1_q <= '0;
      oy0_q <= '0;
      oy1_q <= '0;
    end else begin
      fx0_q <= fx0_d;
      fx1_q <= fx1_d;
      fy0_q <= fy0_d;
      fy1_q <= fy1_d;
      if (frame_end) begin
        lx0_q <= fx0_q;
        lx1_q <= fx1_q;
        ly0_q <= fy0_q;
        ly1_q <= fy1_q;
      end
      if (state_q == DONE && det_new) begin
        ox0_q <= lx0_q;
        ox1_q <= lx1_q;
        oy0_q <= ly0_q;
        oy1_q <= ly1_q;
      end
    end
  end

  // Outline hit: on a vertical or horizontal edge of the published box.
  always_comb begin
    box_hit = det_q &&
              (((x == ox0_q || x == ox1_q) && y >= oy0_q && y <= oy1_q) ||
               ((y == oy0_q || y == oy1_q) && x >= ox0_q && x <= ox1_q));
  end

  assign bbox_x0 = ox0_q;
  assign bbox_x1 = ox1_q;
  assign bbox_y0 = oy0_q;
  assign bbox_y1 = oy1_q;
`else
  assign box_hit = 1'b0;
  assign bbox_x0 = '0;
  assign bbox_x1 = '0;
  assign bbox_y0 = '0;
  assign bbox_y1 = '0;
`endif

  // Overlay select: blanking, crosshair (priority), box outline, passthrough.
  always_comb begin
    rgb_d = {r_in, g_in, b_in};
    if (!img)                                     rgb_d = '0;
    else if (det_q && (x == cx_q || y == cy_q))   rgb_d = XHAIR_RGB;
    else if (box_hit)                             rgb_d = BOX_RGB;
  end

  // One-cycle registered video path.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) rgb_q <= '0;
    else       rgb_q <= rgb_d;
  end

  assign {r_out, g_out, b_out} = rgb_q;
  assign cx             = cx_q;
  assign cy             = cy_q;
  assign cnt            = cnt_q;
  assign detect         = det_q;
  assign busy           = (state_q == DIV_X) || (state_q == DIV_Y);
  assign centroid_valid = (state_q == DONE);

endmodule

// File: tb/tb_blob_tracker.sv
// tb_blob_tracker: scoreboard bench for blob_tracker.
// The driver runs a frame-level model (plain sums, division, min/max) and queues
// expected video and per-frame results; independent monitors pop and compare.
module tb_blob_tracker;
  localparam int XW   = 10;
  localparam int YW   = 9;
  localparam int MINC = 16;

  logic          vga_clk = 1'b0;
  logic          reset   = 1'b1;
  logic          img     = 1'b0;
  logic          vsync   = 1'b1;
  logic [XW-1:0] x       = '0;
  logic [YW-1:0] y       = '0;
  logic [7:0]    r_in = '0, g_in = '0, b_in = '0, lum_thr = 8'd128;
  logic [7:0]    r_out, g_out, b_out;
  logic [XW-1:0] cx, bbox_x0, bbox_x1;
  logic [YW-1:0] cy, bbox_y0, bbox_y1;
  logic [XW+YW-1:0] cnt;
  logic          detect, centroid_valid, busy;

  blob_tracker #(.XW(XW), .YW(YW), .MIN_COUNT(MINC)) dut (
    .vga_clk(vga_clk), .reset(reset), .img(img), .vsync(vsync), .x(x), .y(y),
    .r_in(r_in), .g_in(g_in), .b_in(b_in), .lum_thr(lum_thr),
    .r_out(r_out), .g_out(g_out), .b_out(b_out), .cx(cx), .cy(cy), .cnt(cnt),
    .detect(detect), .centroid_valid(centroid_valid), .busy(busy),
    .bbox_x0(bbox_x0), .bbox_x1(bbox_x1), .bbox_y0(bbox_y0), .bbox_y1(bbox_y1)
  );

  always #20 vga_clk = ~vga_clk;

  typedef struct {
    int cnt; int det; int cx; int cy;
    int bx0; int bx1; int by0; int by1;
    int e;
  } res_t;

  int          errors = 0;
  int          checks = 0;
  int          cyc_n  = 0;
  res_t        res_q[$];
  logic [23:0] vid_q[$];
  res_t        pub, pend;
  bit          pend_v  = 0;
  bit          vs_prev = 0;
  int          f_n, f_bx0, f_bx1, f_by0, f_by1;
  longint      f_sx, f_sy;

  always @(posedge vga_clk) cyc_n++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lum(input int r, input int g, input int b);
    return (r + 2 * g + b) / 4;
  endfunction

  function automatic void fclear();
    f_n = 0; f_sx = 0; f_sy = 0;
    f_bx0 = (1 << XW) - 1; f_bx1 = 0;
    f_by0 = (1 << YW) - 1; f_by1 = 0;
  endfunction

  // Frame end in the model: settle the previous result, then queue this frame's.
  task automatic frame_end_model();
    if (pend_v) begin
      if (cyc_n >= pend.e) pub = pend;
      else void'(res_q.pop_back());
      pend_v = 0;
    end
    pend     = pub;
    pend.cnt = f_n;
    pend.det = (f_n >= MINC) ? 1 : 0;
    if (pend.det != 0) begin
      pend.cx = int'(f_sx / f_n);
      pend.cy = int'(f_sy / f_n);
`ifdef BBOX_EN
      pend.bx0 = f_bx0; pend.bx1 = f_bx1; pend.by0 = f_by0; pend.by1 = f_by1;
`endif
    end
    pend.e = cyc_n + 1 + ((pend.det != 0) ? (XW + YW) : 0);
    res_q.push_back(pend);
    pend_v = 1;
    fclear();
  endtask

  // One pixel clock of stimulus, applied on the falling edge.
  task automatic drive(input bit im, input int px, input int py,
                       input int pr, input int pg, input int pb, input bit vs);
    logic [23:0] e;
    bit          bh;
    @(negedge vga_clk);
    img = im; x = px[XW-1:0]; y = py[YW-1:0];
    r_in = pr[7:0]; g_in = pg[7:0]; b_in = pb[7:0]; vsync = vs;
    if (reset) begin
      vs_prev = 0;
    end else begin
      if (pend_v && cyc_n >= pend.e + 1) begin
        pub = pend;
        pend_v = 0;
      end
      if (vs_prev && !vs) frame_end_model();
      else if (im && lum(pr, pg, pb) >= int'(lum_thr)) begin
        f_n++; f_sx += px; f_sy += py;
        if (px < f_bx0) f_bx0 = px;
        if (px > f_bx1) f_bx1 = px;
        if (py < f_by0) f_by0 = py;
        if (py > f_by1) f_by1 = py;
      end
      bh = 0;
`ifdef BBOX_EN
      bh = (pub.det != 0) &&
           (((px == pub.bx0 || px == pub.bx1) && py >= pub.by0 && py <= pub.by1) ||
            ((py == pub.by0 || py == pub.by1) && px >= pub.bx0 && px <= pub.bx1));
`endif
      if (!im)                                                  e = 24'h0;
      else if (pub.det != 0 && (px == pub.cx || py == pub.cy))  e = 24'hFF0000;
      else if (bh)                                              e = 24'h00FF00;
      else                                                      e = {pr[7:0], pg[7:0], pb[7:0]};
      vid_q.push_back(e);
      vs_prev = vs;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic px(input int xx, input int yy, input int r, input int g, input int b);
    drive(1, xx, yy, r, g, b, 1);
  endtask

  task automatic vfall();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic square();
    for (int yy = 50; yy <= 53; yy++)
      for (int xx = 100; xx <= 103; xx++) px(xx, yy, 255, 255, 255);
    px(5, 5, 0, 0, 0);
  endtask

  task automatic rst_check(input string tag);
    chk({tag, "_rgb"},   {r_out, g_out, b_out}, 0);
    chk({tag, "_cnt"},   cnt, 0);
    chk({tag, "_det"},   detect, 0);
    chk({tag, "_cx"},    cx, 0);
    chk({tag, "_cy"},    cy, 0);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, centroid_valid, 0);
    chk({tag, "_bbox"},  {bbox_x0, bbox_x1, bbox_y0, bbox_y1}, 0);
  endtask

  // Video monitor: each driven cycle's expected pixel appears one edge later.
  always begin
    logic [23:0] ev;
    @(posedge vga_clk); #1;
    if (vid_q.size() > 0) begin
      ev = vid_q.pop_front();
      chk("video", {r_out, g_out, b_out}, ev);
    end
  end

  // Result monitor: valid pulse timing, then published values one cycle later.
  res_t cur;
  bit   cmp_next  = 0;
  bit   busy_prev = 0;
  always begin
    @(posedge vga_clk); #1;
    if (cmp_next) begin
      chk("cnt", cnt, cur.cnt);
      chk("detect", detect, cur.det);
      chk("cx", cx, cur.cx);
      chk("cy", cy, cur.cy);
      chk("bbox", {bbox_x0, bbox_x1, bbox_y0, bbox_y1},
          {cur.bx0[XW-1:0], cur.bx1[XW-1:0], cur.by0[YW-1:0], cur.by1[YW-1:0]});
      cmp_next = 0;
    end
    if (centroid_valid) begin
      if (res_q.size() == 0) begin
        chk("spurious_valid", 1, 0);
      end else begin
        cur = res_q.pop_front();
        chk("valid_time", cyc_n, cur.e);
        chk("busy_at_valid", busy, 0);
        if (cur.det != 0) chk("busy_before_valid", busy_prev, 1);
        cmp_next = 1;
      end
    end
    busy_prev = busy;
  end

  initial begin
    int n;
    pub = '{default: 0};
    fclear();
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 0, 1);
    #1 rst_check("reset");
    reset = 1'b0;
    idle(3);

    // Bright 4x4 square, detect path.
    lum_thr = 8'd128;
    square();
    vfall(); idle(30);

    // Overlay frame: crosshair probes, passthrough and blanking.
    square();
    px(101, 200, 40, 50, 60);
    px(300, 200, 40, 50, 60);
    drive(0, 120, 51, 200, 200, 200, 1);
    vfall(); idle(30);

    // Inclusive threshold: 15 pixels at lum 128, one at 127, no detect.
    for (int yy = 20; yy <= 24; yy++)
      for (int xx = 10; xx <= 12; xx++) px(xx, yy, 128, 128, 128);
    px(30, 30, 127, 127, 127);
    vfall(); idle(30);

    // Second frame end during division aborts the first frame.
    square();
    drive(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) px(7 + i, 7, 255, 255, 255);
    vfall(); idle(30);

    // Reset in the middle of a division.
    square(); idle(2);
    square();
    vfall(); idle(6);
    @(negedge vga_clk);
    reset = 1'b1;
    #1 rst_check("rst_mid");
    if (pend_v && cyc_n < pend.e) void'(res_q.pop_back());
    pend_v = 0;
    pub = '{default: 0};
    fclear();
    vid_q.delete();
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    idle(3);
    square();
    vfall(); idle(30);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      lum_thr = 8'($urandom_range(60, 200));
      n = $urandom_range(5, 45);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 7))
          0: idle(1);
          1: px(pub.cx, $urandom_range(0, 511), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
          2: px($urandom_range(0, 1023), pub.cy, $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255));
          default: px($urandom_range(0, 1023), $urandom_range(0, 511),
                      $urandom_range(0, 255), $urandom_range(0, 255),
                      $urandom_range(0, 255));
        endcase
      end
      idle(1);
      vfall(); idle(25);
    end

    idle(40);
    chk("results_outstanding", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
